// File: rtl/pc_next_unit.sv
// Fetch-stage program counter: next-PC selection (exception, call/return,
// branch, jump, sequential) plus a circular return-address stack.
module pc_next_unit #(
    parameter int              AW        = 32,
    parameter int              DW        = 32,
    parameter int              SHAMT     = 2,
    parameter int              RAS_DEPTH = 4,
    parameter logic [AW-1:0]   RESET_PC  = '0,
    parameter logic [AW-1:0]   EXC_VEC   = AW'(32'h10)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 exc,
    input  logic                 br_taken,
    input  logic signed [DW-1:0] simm,
    input  logic                 jump,
    input  logic                 call,
    input  logic                 ret,
    input  logic [AW-1:0]        jtarget,
    output logic [AW-1:0]        pc,
    output logic [AW-1:0]        pcp1,
    output logic [AW-1:0]        pc_branch,
    output logic                 ras_empty,
    output logic                 ras_full,
    output logic                 ras_uflow
);

    localparam int EW = (AW > DW) ? AW : DW;
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    // Sign-extend to the wider of the two widths before shifting so the
    // arithmetic shift never loses the sign, then truncate to address width.
    function automatic logic [AW-1:0] branch_offset(input logic signed [DW-1:0] imm);
        logic signed [EW-1:0] ext;
        logic signed [EW-1:0] shifted;
        ext     = EW'(imm);
        shifted = ext >>> SHAMT;
        return shifted[AW-1:0];
    endfunction

    logic [AW-1:0] ras [RAS_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top_idx;
    logic [CW-1:0] count;
    logic [AW-1:0] pc_nxt;
    logic          push;
    logic          pop;
    logic          uflow_nxt;

    assign pcp1      = pc + AW'(1);
    assign pc_branch = pcp1 + branch_offset(simm);
    assign ras_empty = (count == '0);
    assign ras_full  = (count == CW'(RAS_DEPTH));
    assign top_idx   = ptr - PW'(1);

    always_comb begin
        pc_nxt    = pcp1;
        push      = 1'b0;
        pop       = 1'b0;
        uflow_nxt = 1'b0;
        if (exc) begin
            pc_nxt = EXC_VEC;
        end else if (stall) begin
            pc_nxt = pc;
        end else if (call) begin
            pc_nxt = jtarget;
            push   = 1'b1;
        end else if (ret && !ras_empty) begin
            pc_nxt = ras[top_idx];
            pop    = 1'b1;
        end else if (ret) begin
            uflow_nxt = 1'b1;
        end else if (br_taken) begin
            pc_nxt = pc_branch;
        end else if (jump) begin
            pc_nxt = jtarget;
        end
    end

    // Control state: PC, stack pointer/occupancy and the underflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            ptr       <= '0;
            count     <= '0;
            ras_uflow <= 1'b0;
        end else begin
            pc        <= pc_nxt;
            ras_uflow <= uflow_nxt;
            if (push) begin
                ptr <= ptr + PW'(1);
                if (!ras_full) begin
                    count <= count + CW'(1);
                end
            end else if (pop) begin
                ptr   <= top_idx;
                count <= count - CW'(1);
            end
        end
    end

    // Stack storage needs no reset: an entry is only read while count > 0.
    // A push on a full stack lands on the oldest slot, overwriting it.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            ras[ptr] <= pcp1;
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: a table of per-cycle vectors with
// hand-computed results, followed by short hand-written reset/RAS sequences.
module tb_pc_next_unit;

    logic               clk = 1'b0;
    logic               rst;
    logic               stall;
    logic               exc;
    logic               br_taken;
    logic signed [31:0] simm;
    logic               jump;
    logic               call;
    logic               ret;
    logic [31:0]        jtarget;
    logic [31:0]        pc;
    logic [31:0]        pcp1;
    logic [31:0]        pc_branch;
    logic               ras_empty;
    logic               ras_full;
    logic               ras_uflow;

    int checks = 0;
    int errors = 0;

    pc_next_unit dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .exc       (exc),
        .br_taken  (br_taken),
        .simm      (simm),
        .jump      (jump),
        .call      (call),
        .ret       (ret),
        .jtarget   (jtarget),
        .pc        (pc),
        .pcp1      (pcp1),
        .pc_branch (pc_branch),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_uflow (ras_uflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, exc, br, jump, call, ret;
        logic [31:0] simm;
        logic [31:0] jt;
        logic        chk_p1;
        logic [31:0] e_pcp1;
        logic        chk_br;
        logic [31:0] e_pcb;
        logic [31:0] e_pc;
        logic        e_empty, e_full, e_uflow;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic e,
                                input logic b, input logic [31:0] im,
                                input logic j, input logic c, input logic rt,
                                input logic [31:0] jt, input logic cp1,
                                input logic [31:0] ep1, input logic cb,
                                input logic [31:0] epb, input logic [31:0] epc,
                                input logic ee, input logic ef, input logic eu);
        vec_t v;
        v.rst = r; v.stall = s; v.exc = e; v.br = b; v.simm = im;
        v.jump = j; v.call = c; v.ret = rt; v.jt = jt;
        v.chk_p1 = cp1; v.e_pcp1 = ep1; v.chk_br = cb; v.e_pcb = epb;
        v.e_pc = epc; v.e_empty = ee; v.e_full = ef; v.e_uflow = eu;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic e, input logic b,
                         input logic [31:0] im, input logic j, input logic c,
                         input logic rt, input logic [31:0] jt);
        rst = r; stall = s; exc = e; br_taken = b; simm = im;
        jump = j; call = c; ret = rt; jtarget = jt;
    endtask

    task automatic step_check(input string tag, input logic [31:0] epc,
                              input logic ee, input logic ef, input logic eu);
        @(posedge clk);
        #1;
        check({tag, " pc"}, pc, epc);
        check({tag, " ras_empty"}, 32'(ras_empty), 32'(ee));
        check({tag, " ras_full"}, 32'(ras_full), 32'(ef));
        check({tag, " ras_uflow"}, 32'(ras_uflow), 32'(eu));
    endtask

    initial begin
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);

        //       rst st ex br simm          jp cl rt jt            cp1 pcp1          cb pcb           pc            emp fu uf
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0));
        for (int i = 1; i <= 5; i++)
            vecs.push_back(mk(0, 0, 0, 0, 32'h0,    0, 0, 0, 32'h0,        1, 32'(i),       0, 32'h0,        32'(i),       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h20,       1, 32'h6,        0, 32'h0,        32'h20,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, -32'sd8,      0, 0, 0, 32'h0,        1, 32'h21,       1, 32'h1F,       32'h1F,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h20,       1, 32'h20,       0, 32'h0,        32'h20,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h40,       0, 0, 0, 32'h0,        1, 32'h21,       1, 32'h31,       32'h31,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 0, 32'h08,       1, 32'h32,       0, 32'h0,        32'h08,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h100,      1, 32'h09,       0, 32'h0,        32'h100,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 32'h101,      0, 32'h0,        32'h09,       1, 0, 0));
        // five calls into a 4-deep stack: the first return address is overwritten
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h200,      1, 32'h0A,       0, 32'h0,        32'h200,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h300,      1, 32'h201,      0, 32'h0,        32'h300,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h400,      1, 32'h301,      0, 32'h0,        32'h400,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h500,      1, 32'h401,      0, 32'h0,        32'h500,      0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h600,      1, 32'h501,      0, 32'h0,        32'h600,      0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 32'h601,      0, 32'h0,        32'h501,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 32'h502,      0, 32'h0,        32'h401,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 32'h402,      0, 32'h0,        32'h301,      0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 32'h302,      0, 32'h0,        32'h201,      1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 32'h202,      0, 32'h0,        32'h202,      1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h203,      0, 32'h0,        32'h203,      1, 0, 0));
        // stall / exception / call+ret interplay
        vecs.push_back(mk(0, 1, 0, 1, 32'h40,       0, 0, 0, 32'h0,        1, 32'h204,      1, 32'h214,      32'h203,      1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h204,      0, 32'h0,        32'h10,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 1, 32'h80,       1, 32'h11,       0, 32'h0,        32'h80,       0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 32'h81,       0, 32'h0,        32'h11,       1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 32'h12,       0, 32'h0,        32'h11,       1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 1, 0, 32'h700,      1, 32'h12,       0, 32'h0,        32'h10,       1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h40,       1, 0, 0, 32'h500,      1, 32'h11,       1, 32'h21,       32'h21,       1, 0, 0));
        // wrap-around and reset against a concurrent call
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 0, 0, 32'hFFFFFFFF, 1, 32'h22,       0, 32'h0,        32'hFFFFFFFF, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0,        32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 1, 0, 32'h40,       1, 32'h1,        0, 32'h0,        32'h40,       0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 1, 0, 32'h90,       1, 32'h41,       0, 32'h0,        32'h0,        1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 0, 1, 32'h0,        1, 32'h1,        0, 32'h0,        32'h1,        1, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].stall, vecs[i].exc, vecs[i].br, vecs[i].simm,
                  vecs[i].jump, vecs[i].call, vecs[i].ret, vecs[i].jt);
            #1;
            if (vecs[i].chk_p1) check({tag, " pcp1"}, pcp1, vecs[i].e_pcp1);
            if (vecs[i].chk_br) check({tag, " pc_branch"}, pc_branch, vecs[i].e_pcb);
            step_check(tag, vecs[i].e_pc, vecs[i].e_empty, vecs[i].e_full, vecs[i].e_uflow);
        end

        // underflow is a single-cycle pulse even when the next cycle stalls
        @(negedge clk); drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step_check("uflow_drop", 32'h1, 1'b1, 1'b0, 1'b0);

        // fill the stack, then reset while a return is requested
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h1000 + 32'(k));
            step_check($sformatf("fill%0d", k), 32'h1000 + 32'(k), 1'b0, k == 3, 1'b0);
        end
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step_check("rst_ret", 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step_check("ret_after_rst", 32'h1, 1'b1, 1'b0, 1'b1);

        // reset also clears a pending underflow pulse
        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        @(posedge clk); #1;
        @(negedge clk); drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step_check("rst_uflow", 32'h0, 1'b1, 1'b0, 1'b0);

        @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
